// File: rtl/exa_crosb_vc_credit_scheduler.sv
// ---------------------------------------------------------------------------
// exa_crosb_vc_credit_scheduler
//
// Per-output-port virtual-channel scheduler. It sits between the crossbar
// output arbiter and the downstream link. It keeps one downstream credit
// counter for every (priority, VC) pair and picks the next pending packet.
// A higher priority always wins over a lower one. VCs of equal priority are
// served round-robin. The winning VC stays selected until the flit marked
// last, and each flit is accepted only while that VC still has a credit.
//
// Flat VC index k = prio*vc_num + vc; priority prio_num-1 is the highest.
//
// Handshake: a flit moves on a rising edge where i_flit_valid and
// o_flit_ready are both high. o_flit_ready does not depend on i_flit_valid.
// The producer keeps the flit (and i_flit_last) stable until that edge.
//
// Ports
//   clk           clock
//   resetn        asynchronous, active-low reset
//   i_vc_req      packet pending, one bit per flat VC index
//   i_credit_ret  one credit returned, one bit per VC (single-cycle pulses)
//   i_flit_valid  flit of the granted packet is valid
//   i_flit_last   the valid flit is the last one of the packet
//   o_flit_ready  a flit is accepted this cycle
//   o_grant       one-hot granted VC, zero when idle
//   o_grant_idx   binary index of o_grant, zero when idle
//   o_busy        a packet is locked (FSM in SEND); doubles as the state view
//   o_credit_cnt  credit counters, VC k at [k*credit_width +: credit_width]
//   o_credit_err  sticky: a credit came back to a counter that was already full
// ---------------------------------------------------------------------------
module exa_crosb_vc_credit_scheduler #(
    parameter int vc_num       = 3,
    parameter int prio_num     = 2,
    parameter int credit_width = 4,
    parameter int max_credits  = 8,
    localparam int N      = vc_num * prio_num,
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1,
    localparam int VC_W   = (vc_num > 1) ? $clog2(vc_num) : 1,
    localparam int PRIO_W = (prio_num > 1) ? $clog2(prio_num) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N-1:0]              i_vc_req,
    input  logic [N-1:0]              i_credit_ret,
    input  logic                      i_flit_valid,
    input  logic                      i_flit_last,
    output logic                      o_flit_ready,
    output logic [N-1:0]              o_grant,
    output logic [IDX_W-1:0]          o_grant_idx,
    output logic                      o_busy,
    output logic [N*credit_width-1:0] o_credit_cnt,
    output logic                      o_credit_err
);

    localparam logic [credit_width-1:0] CRED_MAX = credit_width'(max_credits);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                  state;
    logic [credit_width-1:0] credit [N];
    logic [VC_W-1:0]         rr_ptr [prio_num];
    logic [PRIO_W-1:0]       sel_prio;
    logic [VC_W-1:0]         sel_vc;

    logic [N-1:0]            eligible;
    logic                    win_found;
    logic [PRIO_W-1:0]       win_prio;
    logic [VC_W-1:0]         win_vc;
    logic [IDX_W-1:0]        win_idx;
    logic                    xfer;
    logic [N-1:0]            xfer_vec;

    // A VC can win only if it has a packet pending and at least one credit.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            eligible[k] = i_vc_req[k] && (credit[k] != '0);
        end
    end

    // Pick the highest level that has any eligible VC. Inside that level,
    // search round-robin starting just after that level's last winner.
    always_comb begin
        int v;
        v         = 0;
        win_found = 1'b0;
        win_prio  = '0;
        win_vc    = '0;
        for (int p = prio_num - 1; p >= 0; p--) begin
            for (int o = 1; o <= vc_num; o++) begin
                v = (int'(rr_ptr[p]) + o) % vc_num;
                if (!win_found && eligible[p*vc_num + v]) begin
                    win_found = 1'b1;
                    win_prio  = PRIO_W'(p);
                    win_vc    = VC_W'(v);
                end
            end
        end
    end

    assign win_idx = IDX_W'(int'(win_prio) * vc_num + int'(win_vc));

    // Ready follows the locked VC's credit. It can drop mid-packet and
    // recover when a credit returns.
    assign o_busy       = (state == S_SEND);
    assign o_flit_ready = o_busy && (credit[o_grant_idx] != '0);
    assign xfer         = i_flit_valid && o_flit_ready;
    assign xfer_vec     = o_grant & {N{xfer}};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            o_grant     <= '0;
            o_grant_idx <= '0;
            sel_prio    <= '0;
            sel_vc      <= '0;
            for (int p = 0; p < prio_num; p++) begin
                rr_ptr[p] <= VC_W'(vc_num - 1);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        state       <= S_SEND;
                        o_grant     <= N'(1) << win_idx;
                        o_grant_idx <= win_idx;
                        sel_prio    <= win_prio;
                        sel_vc      <= win_vc;
                    end
                end
                S_SEND: begin
                    // Requests are ignored here. Only the last flit ends the lock.
                    if (xfer && i_flit_last) begin
                        state            <= S_IDLE;
                        o_grant          <= '0;
                        o_grant_idx      <= '0;
                        rr_ptr[sel_prio] <= sel_vc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Credit counters. A return and a transfer on the same VC cancel out.
    // A return to a full counter is dropped and flagged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_credit_err <= 1'b0;
            for (int k = 0; k < N; k++) begin
                credit[k] <= CRED_MAX;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                case ({i_credit_ret[k], xfer_vec[k]})
                    2'b10: begin
                        if (credit[k] == CRED_MAX) begin
                            o_credit_err <= 1'b1;
                        end else begin
                            credit[k] <= credit[k] + 1'b1;
                        end
                    end
                    2'b01:   credit[k] <= credit[k] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            o_credit_cnt[k*credit_width +: credit_width] = credit[k];
        end
    end

endmodule

// File: tb/tb_exa_crosb_vc_credit_scheduler.sv
module tb_exa_crosb_vc_credit_scheduler;

    localparam int N     = 6;
    localparam int IDX_W = 3;
    localparam int CW    = 4;

    // clock / reset
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [N-1:0]      i_vc_req;
    logic [N-1:0]      i_credit_ret;
    logic              i_flit_valid;
    logic              i_flit_last;
    logic              o_flit_ready;
    logic [N-1:0]      o_grant;
    logic [IDX_W-1:0]  o_grant_idx;
    logic              o_busy;
    logic [N*CW-1:0]   o_credit_cnt;
    logic              o_credit_err;

    exa_crosb_vc_credit_scheduler dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_vc_req     (i_vc_req),
        .i_credit_ret (i_credit_ret),
        .i_flit_valid (i_flit_valid),
        .i_flit_last  (i_flit_last),
        .o_flit_ready (o_flit_ready),
        .o_grant      (o_grant),
        .o_grant_idx  (o_grant_idx),
        .o_busy       (o_busy),
        .o_credit_cnt (o_credit_cnt),
        .o_credit_err (o_credit_err)
    );

    int checks   = 0;
    int failures = 0;

    // scoreboard: {expected idx, expected one-hot grant} per packet
    logic [IDX_W+N-1:0] exp_q[$];

    typedef struct {
        logic [N-1:0] req;
        int           exp_idx;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx);
        logic [N-1:0] oh;
        oh = N'(1) << idx;
        exp_q.push_back({IDX_W'(idx), oh});
    endtask

    function automatic logic [CW-1:0] cred(input int k);
        return o_credit_cnt[k*CW +: CW];
    endfunction

    // monitor: every new grant is compared against the scoreboard
    logic busy_q = 1'b0;
    always begin
        logic [IDX_W+N-1:0] e;
        @(posedge clk);
        #2;
        if (o_busy && !busy_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL grant_unexpected: got idx %0d grant %b, none expected", o_grant_idx, o_grant);
            end else begin
                e = exp_q.pop_front();
                if ({o_grant_idx, o_grant} !== e) begin
                    failures++;
                    $display("FAIL grant_order: got idx %0d grant %b expected idx %0d grant %b",
                             o_grant_idx, o_grant, e[IDX_W+N-1:N], e[N-1:0]);
                end
            end
        end
        busy_q = o_busy;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{6'b000001, 0};
        vecs[1] = '{6'b001001, 3};
        vecs[2] = '{6'b000111, 1};
        vecs[3] = '{6'b000111, 2};
        vecs[4] = '{6'b000111, 0};
        vecs[5] = '{6'b111000, 4};
        vecs[6] = '{6'b101000, 5};
        vecs[7] = '{6'b110111, 4};
        vecs[8] = '{6'b000110, 1};
        vecs[9] = '{6'b100100, 5};

        resetn = 1'b0; i_vc_req = '0; i_credit_ret = '0; i_flit_valid = 1'b0; i_flit_last = 1'b0;
        repeat (2) tick();
        check("rst_grant", 32'(o_grant), 0);
        check("rst_idx", 32'(o_grant_idx), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_ready", 32'(o_flit_ready), 0);
        check("rst_err", 32'(o_credit_err), 0);
        for (int k = 0; k < N; k++) check($sformatf("rst_cred%0d", k), 32'(cred(k)), 8);
        resetn = 1'b1;
        tick();

        // 4-flit packet on idx0; a request change mid-packet must not move the lock
        i_vc_req = 6'b000001; push_exp(0);
        tick();
        check("p4_ready", 32'(o_flit_ready), 1);
        i_flit_valid = 1'b1; i_vc_req = 6'b100000;
        tick();
        check("p4_locked", 32'(o_grant), 32'h1);
        tick(); tick();
        i_flit_last = 1'b1; i_vc_req = '0;
        tick();
        i_flit_valid = 1'b0; i_flit_last = 1'b0;
        check("p4_busy_off", 32'(o_busy), 0);
        check("p4_grant_off", 32'(o_grant), 0);
        check("p4_cred0", 32'(cred(0)), 4);

        // valid while idle is ignored
        i_flit_valid = 1'b1;
        tick();
        check("idle_ready", 32'(o_flit_ready), 0);
        check("idle_cred0", 32'(cred(0)), 4);
        i_flit_valid = 1'b0;
        tick();

        // arbitration table: single-flit packets, one idle cycle between
        for (int i = 0; i < 10; i++) begin
            i_vc_req = vecs[i].req; push_exp(vecs[i].exp_idx);
            tick();
            check($sformatf("tbl%0d_ready", i), 32'(o_flit_ready), 1);
            i_flit_valid = 1'b1; i_flit_last = 1'b1; i_vc_req = '0;
            tick();
            i_flit_valid = 1'b0; i_flit_last = 1'b0;
            check($sformatf("tbl%0d_done", i), 32'(o_busy), 0);
            tick();
        end
        check("tbl_cred0", 32'(cred(0)), 2);
        check("tbl_cred4", 32'(cred(4)), 6);

        // reset mid-packet
        i_vc_req = 6'b000100; push_exp(2);
        tick();
        i_flit_valid = 1'b1; i_vc_req = '0;
        tick();
        check("mid_cred2", 32'(cred(2)), 6);
        resetn = 1'b0;
        #1;
        check("mid_rst_grant", 32'(o_grant), 0);
        check("mid_rst_busy", 32'(o_busy), 0);
        check("mid_rst_ready", 32'(o_flit_ready), 0);
        for (int k = 0; k < N; k++) check($sformatf("mid_rst_cred%0d", k), 32'(cred(k)), 8);
        i_flit_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // credit starvation on idx1
        i_vc_req = 6'b000010; push_exp(1);
        tick();
        i_flit_valid = 1'b1; i_vc_req = '0;
        repeat (8) tick();
        check("starve_cred1", 32'(cred(1)), 0);
        check("starve_ready", 32'(o_flit_ready), 0);
        check("starve_busy", 32'(o_busy), 1);
        repeat (2) tick();
        check("starve_hold", 32'(cred(1)), 0);
        i_credit_ret = 6'b000010;
        tick();
        i_credit_ret = '0;
        check("starve_ret_cred", 32'(cred(1)), 1);
        check("starve_ret_ready", 32'(o_flit_ready), 1);
        tick();
        check("starve_one_cred", 32'(cred(1)), 0);
        check("starve_one_ready", 32'(o_flit_ready), 0);
        i_credit_ret = 6'b000010;
        tick();
        i_credit_ret = '0; i_flit_last = 1'b1;
        tick();
        i_flit_valid = 1'b0; i_flit_last = 1'b0;
        check("starve_end_busy", 32'(o_busy), 0);
        check("starve_end_cred", 32'(cred(1)), 0);

        // zero credit blocks the grant until a credit returns
        i_vc_req = 6'b000010;
        repeat (3) tick();
        check("zc_no_grant", 32'(o_busy), 0);
        push_exp(1);
        i_credit_ret = 6'b000010;
        tick();
        i_credit_ret = '0;
        check("zc_wait", 32'(o_busy), 0);
        check("zc_cred", 32'(cred(1)), 1);
        tick();
        check("zc_grant", 32'(o_busy), 1);
        i_flit_valid = 1'b1; i_flit_last = 1'b1; i_vc_req = '0;
        tick();
        i_flit_valid = 1'b0; i_flit_last = 1'b0;
        check("zc_done", 32'(o_busy), 0);
        tick();

        // same-cycle return + transfer, then overflow error
        i_vc_req = 6'b000001; push_exp(0);
        tick();
        i_vc_req = '0; i_flit_valid = 1'b1; i_credit_ret = 6'b000001;
        tick();
        i_credit_ret = '0;
        check("net0_cred", 32'(cred(0)), 8);
        check("net0_err", 32'(o_credit_err), 0);
        tick();
        check("dec_cred", 32'(cred(0)), 7);
        i_flit_last = 1'b1;
        tick();
        i_flit_valid = 1'b0; i_flit_last = 1'b0;
        check("dec2_cred", 32'(cred(0)), 6);
        repeat (2) begin
            i_credit_ret = 6'b000001;
            tick();
            i_credit_ret = '0;
        end
        check("fill_cred", 32'(cred(0)), 8);
        check("fill_err", 32'(o_credit_err), 0);
        i_credit_ret = 6'b000001;
        tick();
        i_credit_ret = '0;
        check("ovf_cred", 32'(cred(0)), 8);
        check("ovf_err", 32'(o_credit_err), 1);
        repeat (2) tick();
        check("ovf_sticky", 32'(o_credit_err), 1);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
